// File: rtl/sobol_pkg.sv
// Shared defaults, FSM state encoding and the per-request tag that rides the
// tag FIFO alongside each outstanding Sobol request.
package sobol_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int M_DEF     = 50;
  localparam int DIMW_DEF  = $clog2(M_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DIMW_DEF-1:0] dim;
    logic                last_dim;
    logic                last_path;
  } tag_t;

endpackage

// File: rtl/sobol_tag_fifo.sv
// Small tag FIFO with a registered occupancy count; the head entry is visible
// combinationally so tags line up with the generator's result beats.
module sobol_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push is accepted even when full.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/sobol_seq_ctrl.sv
// Sequences (index, dim) requests path-major into a Sobol generator and tags
// its results. Define SOBOL_SEQ_SKIP0_EN to start at base+1 (skips point 0).
module sobol_seq_ctrl
  import sobol_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int M         = M_DEF,
  parameter  int TAG_DEPTH = 4,
  localparam int DIMW      = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_base_idx,
  input  logic [WIDTH-1:0] cmd_n_paths,
  input  logic [DIMW-1:0]  cmd_n_dims,
  output logic             gen_valid_in,
  input  logic             gen_ready_out,
  output logic [WIDTH-1:0] gen_idx_in,
  output logic [DIMW-1:0]  gen_dim_in,
  input  logic             gen_valid_out,
  output logic             gen_ready_in,
  input  logic [WIDTH-1:0] gen_sobol_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [DIMW-1:0]  out_dim,
  output logic             out_last_dim,
  output logic             out_last_path,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef SOBOL_SEQ_SKIP0_EN
  localparam logic [WIDTH-1:0] IDX_OFS = WIDTH'(1);
`else
  localparam logic [WIDTH-1:0] IDX_OFS = '0;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] idx_reg;
  logic [WIDTH-1:0] path_reg;
  logic [WIDTH-1:0] n_paths_reg;
  logic [DIMW-1:0]  dim_reg;
  logic [DIMW-1:0]  n_dims_reg;
  logic             done_reg;
  logic             err_reg;
  logic             cmd_fire, gen_fire, out_fire;
  logic             zero_cmd, last_dim, last_path;
  logic             fifo_full, fifo_empty;
  tag_t             push_tag, head_tag;

  assign cmd_ready = (state_reg == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign zero_cmd  = (n_paths_reg == '0) || (n_dims_reg == '0);
  assign last_dim  = (dim_reg == n_dims_reg - 1'b1);
  assign last_path = (path_reg == n_paths_reg - 1'b1);

  // FIFO can only drain while a request waits, so valid never drops before ready.
  assign gen_valid_in = (state_reg == ISSUE) && !zero_cmd && !fifo_full;
  assign gen_idx_in   = idx_reg;
  assign gen_dim_in   = dim_reg;
  assign gen_fire     = gen_valid_in && gen_ready_out;

  assign out_valid     = gen_valid_out;
  assign out_data      = gen_sobol_out;
  assign gen_ready_in  = out_ready;
  assign out_fire      = gen_valid_out && out_ready;
  assign out_dim       = DIMW'(head_tag.dim);
  assign out_last_dim  = head_tag.last_dim;
  assign out_last_path = head_tag.last_path;

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign err  = err_reg;

  always_comb begin
    push_tag           = '0;
    push_tag.dim       = DIMW_DEF'(dim_reg);
    push_tag.last_dim  = last_dim;
    push_tag.last_path = last_dim && last_path;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_fire) state_next = ISSUE;
      ISSUE: begin
        if (zero_cmd)                               state_next = IDLE;
        else if (gen_fire && last_dim && last_path) state_next = DRAIN;
      end
      DRAIN:   if (fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      path_reg    <= '0;
      n_paths_reg <= '0;
      dim_reg     <= '0;
      n_dims_reg  <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg != IDLE) && (state_next == IDLE);
      // A result with no outstanding tag cannot be labelled; flag it and drop nothing.
      if (gen_valid_out && fifo_empty) err_reg <= 1'b1;
      if (cmd_fire) begin
        n_paths_reg <= cmd_n_paths;
        n_dims_reg  <= cmd_n_dims;
        idx_reg     <= cmd_base_idx + IDX_OFS;
        path_reg    <= '0;
        dim_reg     <= '0;
      end else if (gen_fire) begin
        if (last_dim) begin
          dim_reg  <= '0;
          path_reg <= path_reg + 1'b1;
          idx_reg  <= idx_reg + 1'b1;
        end else begin
          dim_reg  <= dim_reg + 1'b1;
        end
      end
    end
  end

  sobol_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .DW    ($bits(tag_t))
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gen_fire),
    .wdata (push_tag),
    .pop   (out_fire),
    .rdata (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sobol_seq_ctrl.sv
// Scoreboard bench: expected requests and tagged beats are queued per command,
// a behavioural generator answers the DUT's requests after a random latency.
`timescale 1ns/1ps
module tb_sobol_seq_ctrl;

  localparam int WIDTH     = 32;
  localparam int M         = 50;
  localparam int TAG_DEPTH = 4;
  localparam int DIMW      = $clog2(M);
`ifdef SOBOL_SEQ_SKIP0_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_base_idx = '0;
  logic [WIDTH-1:0] cmd_n_paths = '0;
  logic [DIMW-1:0]  cmd_n_dims = '0;
  logic             gen_valid_in;
  logic             gen_ready_out = 1'b0;
  logic [WIDTH-1:0] gen_idx_in;
  logic [DIMW-1:0]  gen_dim_in;
  logic             gen_valid_out = 1'b0;
  logic             gen_ready_in;
  logic [WIDTH-1:0] gen_sobol_out = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [DIMW-1:0]  out_dim;
  logic             out_last_dim, out_last_path;
  logic             busy, done, err;

  always #5 clk = ~clk;

  sobol_seq_ctrl #(.WIDTH(WIDTH), .M(M), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_idx(cmd_base_idx), .cmd_n_paths(cmd_n_paths), .cmd_n_dims(cmd_n_dims),
    .gen_valid_in(gen_valid_in), .gen_ready_out(gen_ready_out),
    .gen_idx_in(gen_idx_in), .gen_dim_in(gen_dim_in),
    .gen_valid_out(gen_valid_out), .gen_ready_in(gen_ready_in), .gen_sobol_out(gen_sobol_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dim(out_dim),
    .out_last_dim(out_last_dim), .out_last_path(out_last_path),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct { logic [WIDTH-1:0] idx; logic [DIMW-1:0] dim; } req_t;
  typedef struct { logic [WIDTH-1:0] data; logic [DIMW-1:0] dim; logic ld; logic lp; } beat_t;
  typedef struct { logic [WIDTH-1:0] data; int avail; } gres_t;

  req_t  req_q[$];
  beat_t exp_q[$];
  gres_t pipe_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int fires, pops, outstanding, done_cnt, done_cyc, cmd_fire_cyc, gv_cycles, hold_cnt, fires_at_first_pop;
  bit prev_gv, prev_gfire;
  logic [WIDTH-1:0] prev_idx;
  logic [DIMW-1:0]  prev_dim;
  bit gen_rand, out_rand;
  int gen_lat_max, stall_at_fire = -1, stall_len = 0, stall_left = 0, out_hold_left = 0;

  function automatic logic [WIDTH-1:0] sob(input logic [WIDTH-1:0] i, input logic [DIMW-1:0] d);
    return (i * 32'h9E37_79B1) ^ (WIDTH'(d) << 24) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic set_policy(input bit gr, input bit orr, input int lat);
    gen_rand = gr; out_rand = orr; gen_lat_max = lat;
    stall_at_fire = -1; stall_len = 0; stall_left = 0; out_hold_left = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_base_idx = '0; cmd_n_paths = '0; cmd_n_dims = '0;
    gen_ready_out = 1'b0; gen_valid_out = 1'b0; gen_sobol_out = '0; out_ready = 1'b0;
    req_q.delete(); exp_q.delete(); pipe_q.delete();
    outstanding = 0; prev_gv = 1'b0; prev_gfire = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: observe at the falling edge, drive new inputs just after the rising edge.
  task automatic tick();
    bit gfire, ofire, cfire;
    req_t r;
    beat_t b;
    @(negedge clk);
    cyc++;
    if (prev_gv && !prev_gfire) begin
      checks++; hold_cnt++;
      if (gen_valid_in !== 1'b1 || gen_idx_in !== prev_idx || gen_dim_in !== prev_dim) begin
        errors++;
        $display("FAIL req_hold: got valid=%0b idx=%h dim=%0d, expected valid=1 idx=%h dim=%0d",
                 gen_valid_in, gen_idx_in, gen_dim_in, prev_idx, prev_dim);
      end
    end
    if (outstanding >= TAG_DEPTH) begin
      checks++;
      if (gen_valid_in !== 1'b0) begin
        errors++;
        $display("FAIL full_block: got gen_valid_in=%0b with %0d tags pending, expected 0", gen_valid_in, outstanding);
      end
    end
    gfire = (gen_valid_in === 1'b1) && (gen_ready_out === 1'b1);
    ofire = (out_valid === 1'b1) && (out_ready === 1'b1);
    cfire = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
    if (gen_valid_in === 1'b1) gv_cycles++;
    if (gfire) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL req_extra: got idx=%h dim=%0d, expected no request", gen_idx_in, gen_dim_in);
      end else begin
        r = req_q.pop_front();
        if (gen_idx_in !== r.idx || gen_dim_in !== r.dim) begin
          errors++;
          $display("FAIL req: got idx=%h dim=%0d, expected idx=%h dim=%0d", gen_idx_in, gen_dim_in, r.idx, r.dim);
        end
      end
      pipe_q.push_back('{sob(gen_idx_in, gen_dim_in), cyc + 1 + int'($urandom_range(gen_lat_max))});
      fires++; outstanding++;
    end
    if (ofire) begin
      checks++;
      if (pops == 0) fires_at_first_pop = fires;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_extra: got data=%h dim=%0d, expected no beat", out_data, out_dim);
      end else begin
        b = exp_q.pop_front();
        if (out_data !== b.data || out_dim !== b.dim || out_last_dim !== b.ld || out_last_path !== b.lp) begin
          errors++;
          $display("FAIL beat: got data=%h dim=%0d ld=%0b lp=%0b, expected data=%h dim=%0d ld=%0b lp=%0b",
                   out_data, out_dim, out_last_dim, out_last_path, b.data, b.dim, b.ld, b.lp);
        end
      end
      if (pipe_q.size() != 0) void'(pipe_q.pop_front());
      pops++; outstanding--;
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (cfire) cmd_fire_cyc = cyc;
    prev_gv = (gen_valid_in === 1'b1); prev_gfire = gfire; prev_idx = gen_idx_in; prev_dim = gen_dim_in;
    @(posedge clk);
    #1;
    if (cfire) cmd_valid = 1'b0;
    if (stall_at_fire >= 0 && fires >= stall_at_fire) begin stall_left = stall_len; stall_at_fire = -1; end
    if (stall_left > 0) begin gen_ready_out = 1'b0; stall_left--; end
    else gen_ready_out = gen_rand ? 1'($urandom_range(1)) : 1'b1;
    if (out_hold_left > 0) begin out_ready = 1'b0; out_hold_left--; end
    else out_ready = out_rand ? 1'($urandom_range(1)) : 1'b1;
    if (pipe_q.size() != 0 && pipe_q[0].avail <= cyc) begin
      gen_valid_out = 1'b1; gen_sobol_out = pipe_q[0].data;
    end else begin
      gen_valid_out = 1'b0; gen_sobol_out = '0;
    end
  endtask

  task automatic queue_cmd(input logic [WIDTH-1:0] base, input int np, input int nd, input bit beats);
    logic [WIDTH-1:0] ix;
    logic [DIMW-1:0]  dd;
    for (int p = 0; p < np; p++) begin
      for (int d = 0; d < nd; d++) begin
        ix = base + WIDTH'(p) + WIDTH'(SKIP);
        dd = DIMW'(d);
        req_q.push_back('{ix, dd});
        if (beats) exp_q.push_back('{sob(ix, dd), dd, d == nd - 1, (p == np - 1) && (d == nd - 1)});
      end
    end
    fires = 0; pops = 0; done_cnt = 0; gv_cycles = 0; hold_cnt = 0;
    fires_at_first_pop = -1; cmd_fire_cyc = -1; done_cyc = -1;
    cmd_base_idx = base; cmd_n_paths = WIDTH'(np); cmd_n_dims = DIMW'(nd); cmd_valid = 1'b1;
  endtask

  task automatic run_cmd(input logic [WIDTH-1:0] base, input int np, input int nd, input string name);
    int n;
    queue_cmd(base, np, nd, 1'b1);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin tick(); n++; end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected a done pulse", name, n);
    end
    tick(); tick();
    checks++;
    if (done_cnt != 1 || req_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_complete: got done_pulses=%0d reqs_left=%0d beats_left=%0d, expected 1/0/0",
               name, done_cnt, req_q.size(), exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%0b cmd_ready=%0b err=%0b, expected 0/1/0", name, busy, cmd_ready, err);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({cmd_ready, gen_valid_in, busy, done, err, out_valid} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/gv/busy/done/err/ov=%b, expected 100000",
               {cmd_ready, gen_valid_in, busy, done, err, out_valid});
    end
    checks++;
    if (gen_idx_in !== '0 || gen_dim_in !== '0) begin
      errors++;
      $display("FAIL reset_req: got idx=%h dim=%0d, expected 0/0", gen_idx_in, gen_dim_in);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    set_policy(1'b0, 1'b0, 0);
    run_cmd(32'h0, 2, 3, "basic");
    checks++;
    if (fires != 6 || pops != 6) begin
      errors++;
      $display("FAIL basic_count: got fires=%0d pops=%0d, expected 6/6", fires, pops);
    end
  endtask

  task automatic test_gen_stall();
    set_policy(1'b0, 1'b0, 0);
    stall_at_fire = 2; stall_len = 5;
    run_cmd(32'h40, 2, 3, "gen_stall");
    checks++;
    if (hold_cnt != 5 || fires != 6) begin
      errors++;
      $display("FAIL gen_stall_count: got held=%0d fires=%0d, expected 5/6", hold_cnt, fires);
    end
  endtask

  task automatic test_backpressure();
    set_policy(1'b0, 1'b0, 2);
    out_hold_left = 20;
    run_cmd(32'h7, 3, 3, "backpressure");
    checks++;
    if (fires_at_first_pop != TAG_DEPTH) begin
      errors++;
      $display("FAIL bp_depth: got %0d fires before first pop, expected %0d", fires_at_first_pop, TAG_DEPTH);
    end
  endtask

  task automatic test_zero();
    set_policy(1'b0, 1'b0, 0);
    run_cmd(32'h5, 0, 3, "zero_paths");
    checks++;
    if (gv_cycles != 0 || done_cyc - cmd_fire_cyc != 2) begin
      errors++;
      $display("FAIL zero_paths_timing: got gv_cycles=%0d done_delay=%0d, expected 0/2", gv_cycles, done_cyc - cmd_fire_cyc);
    end
    run_cmd(32'h5, 4, 0, "zero_dims");
    checks++;
    if (gv_cycles != 0 || done_cyc - cmd_fire_cyc != 2) begin
      errors++;
      $display("FAIL zero_dims_timing: got gv_cycles=%0d done_delay=%0d, expected 0/2", gv_cycles, done_cyc - cmd_fire_cyc);
    end
  endtask

  task automatic test_wrap();
    set_policy(1'b0, 1'b0, 1);
    run_cmd(32'hFFFF_FFFF, 2, 1, "wrap");
  endtask

  task automatic test_skip0();
    set_policy(1'b0, 1'b0, 0);
    run_cmd(32'h0, 1, 1, "skip0");
    checks++;
    if (fires != 1) begin
      errors++;
      $display("FAIL skip0_count: got fires=%0d, expected 1", fires);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_policy(1'b0, 1'b0, 0);
    out_hold_left = 1000;
    queue_cmd(32'h20, 1, 2, 1'b0);
    n = 0;
    while (fires < 2 && n < 100) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (busy !== 1'b1 || outstanding != 2) begin
      errors++;
      $display("FAIL rmid_drain: got busy=%0b pending=%0d, expected 1/2", busy, outstanding);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gen_valid_in, busy, done, err} !== 4'b0000 || gen_idx_in !== '0 || gen_dim_in !== '0) begin
      errors++;
      $display("FAIL rmid_async: got gv/busy/done/err=%b idx=%h dim=%0d, expected 0000/0/0",
               {gen_valid_in, busy, done, err}, gen_idx_in, gen_dim_in);
    end
    gen_valid_out = 1'b0; gen_sobol_out = '0; out_ready = 1'b0; gen_ready_out = 1'b0;
    req_q.delete(); exp_q.delete(); pipe_q.delete();
    outstanding = 0; prev_gv = 1'b0; prev_gfire = 1'b0; out_hold_left = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL rmid_nodone: got done=%0b during reset, expected 0", done);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_release: got cmd_ready=%0b err=%0b, expected 1/0", cmd_ready, err);
    end
    @(posedge clk); #1;
    run_cmd(32'h3, 2, 2, "rmid_after");
  endtask

  task automatic test_back_to_back();
    set_policy(1'b1, 1'b1, 3);
    run_cmd(32'd100, 3, 4, "b2b_a");
    run_cmd(32'd200, 5, 2, "b2b_b");
    run_cmd(32'd9, 1, M, "b2b_maxdim");
  endtask

  task automatic test_err();
    set_policy(1'b0, 1'b0, 0);
    out_ready = 1'b1;
    gen_valid_out = 1'b1; gen_sobol_out = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    gen_valid_out = 1'b0; gen_sobol_out = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got err=%0b busy=%0b, expected 1/0", err, busy);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%0b after reset, expected 0", err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_policy(1'b0, 1'b0, 0);
    test_reset();
    test_basic();
    test_gen_stall();
    test_backpressure();
    test_zero();
    test_wrap();
    test_skip0();
    test_reset_mid();
    test_back_to_back();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobol_seq_ctrl.md
SOBOL_SEQ_CTRL -- requirements
Module: sobol_seq_ctrl

Interface
REQ-001 Parameters SHALL be:
  - WIDTH, 32, index/sample width.
  - M, 50, maximum dimension count.
  - TAG_DEPTH, 4, maximum samples in flight inside the generator.
  - DIMW = $clog2(M), derived.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-005 cmd_base_idx  in  WIDTH  first Sobol index; cmd_n_paths  in  WIDTH  path count; cmd_n_dims  in  DIMW  dimensions per path, legal 0..M.
REQ-006 gen_valid_in/gen_ready_out  out/in  1/1  request handshake to sobol.
REQ-007 gen_idx_in  out  WIDTH; gen_dim_in  out  DIMW  request fields to sobol.
REQ-008 gen_valid_out/gen_ready_in  in/out  1/1  sobol result handshake; gen_sobol_out  in  WIDTH  sample.
REQ-009 out_valid/out_ready  out/in  1/1  tagged sample stream to consumer.
REQ-010 out_data  out  WIDTH; out_dim  out  DIMW; out_last_dim, out_last_path  out  1  tags of the current beat.
REQ-011 busy  out  1; done  out  1  one-cycle completion pulse; err  out  1  sticky protocol error.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE and DRAIN; cmd_ready=1 only in IDLE.
REQ-013 On cmd fire in IDLE: latch fields, clear path/dim counters, go to ISSUE; gen_valid_in may first assert the next cycle.
REQ-014 A command with n_paths=0 or n_dims=0 SHALL issue nothing: go to IDLE, done=1 on the following cycle.
REQ-015 Issue order SHALL be path-major: gen_idx_in=base+p (mod 2^WIDTH), gen_dim_in=d, d from 0 to n_dims-1, then p+1.
REQ-016 gen_valid_in SHALL assert in ISSUE only when the tag FIFO is not full; once asserted, it and idx/dim stay stable until gen_ready_out.
REQ-017 Each request fire SHALL push tag {d, d==n_dims-1, p==n_paths-1 && d==n_dims-1} and advance counters.
REQ-018 After the final request fire, ISSUE SHALL go to DRAIN.
REQ-019 The output path SHALL be pass-through:
  - out_valid=gen_valid_out, out_data=gen_sobol_out, gen_ready_in=out_ready.
  - out_dim/out_last_* come from the FIFO head.
  - Pop on gen_valid_out && out_ready.
REQ-020 A simultaneous push and pop SHALL be legal at any occupancy; occupancy is unchanged.
REQ-021 gen_valid_out while the FIFO is empty SHALL set err (sticky until reset) and pop nothing.
REQ-022 DRAIN SHALL go to IDLE when the FIFO is empty; done=1 for exactly the first IDLE cycle.
REQ-023 busy SHALL be 1 in ISSUE and DRAIN, otherwise 0.
REQ-024 Counters SHALL be WIDTH bits (path) and DIMW bits (dim); index wraps modulo 2^WIDTH without error.

Reset
REQ-025 rst_n low at any time, including mid-command, SHALL asynchronously force:
  - state IDLE, FIFO empty, all counters 0.
  - cmd_ready=1 once released; gen_valid_in=0, gen_idx_in=0, gen_dim_in=0.
  - busy=0, done=0, err=0.
REQ-026 In-flight requests SHALL be discarded on reset with no done pulse.

Configuration
REQ-027 With SOBOL_SEQ_SKIP0_EN defined, issued indices SHALL be base+1..base+n_paths, so Sobol point 0 (all zeros) is never requested.
REQ-028 Without SOBOL_SEQ_SKIP0_EN, issued indices SHALL be base..base+n_paths-1.

Structure
REQ-029 sobol_pkg SHALL hold WIDTH, M and DIMW defaults and the tag struct typedef {dim, last_dim, last_path}.
REQ-030 The tag FIFO SHALL be sub-module sobol_tag_fifo: depth TAG_DEPTH, registered count, full/empty outputs.

Verification
REQ-031 base=0, paths=2, dims=3, all ready=1 -> requests (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); out_last_dim on beats 3 and 6; out_last_path on beat 6 only; one done pulse.
REQ-032 gen_ready_out low 5 cycles mid-run -> gen_valid_in/idx/dim held stable; no duplicate or skipped request.
REQ-033 out_ready=0 with generator stalling, TAG_DEPTH=4 -> at most 4 request fires before the first pop; gen_valid_in low while full.
REQ-034 paths=0 -> no gen_valid_in; done=1 two cycles after cmd fire; base=0xFFFFFFFF, paths=2 -> indices 0xFFFFFFFF, 0x0.
REQ-035 rst_n low during DRAIN with 2 tags pending -> all outputs at reset values; new command runs cleanly with no err.
REQ-036 SOBOL_SEQ_SKIP0_EN defined, base=0, paths=1, dims=1 -> single request idx=1.
